// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush/redirect sequencer.
// Holds the FSM state encoding, the pipe-control bundle and default widths.
package pipeline_ctrl_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int RADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic bubble_ex;
        logic flush_front;
        logic flush_all;
    } pipe_ctrl_t;

    function automatic pipe_ctrl_t stall_all();
        pipe_ctrl_t c;
        c          = '0;
        c.stall_if = 1'b1;
        c.stall_id = 1'b1;
        c.stall_ex = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the decode operands and a load in execute.
// Purely combinational; x0 never creates a dependency.
module pipeline_ctrl_hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  logic               i_id_valid,
    input  logic [RADDR_W-1:0] i_id_rs1,
    input  logic [RADDR_W-1:0] i_id_rs2,
    input  logic               i_id_use_rs1,
    input  logic               i_id_use_rs2,
    input  logic               i_ex_load,
    input  logic [RADDR_W-1:0] i_ex_rd,
    output logic               o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_load_use = i_id_valid && i_ex_load && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage core: load-use and memory stalls,
// branch redirects, and trap/interrupt entry (drain memory, flush, redirect PC).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic               ex_load,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               if_busy,
    input  logic               mem_busy,
    input  logic               br_taken,
    input  logic [XLEN-1:0]    br_target,
    input  logic               trap_req,
    input  logic [XLEN-1:0]    trap_target,
    input  logic               irq_pending,
    input  logic [XLEN-1:0]    irq_target,
    output logic               stall_if,
    output logic               stall_id,
    output logic               stall_ex,
    output logic               bubble_ex,
    output logic               flush_front,
    output logic               flush_all,
    output logic               pc_redirect,
    output logic [XLEN-1:0]    pc_target,
    output logic               irq_take,
    output ctrl_state_t        dbg_state
);

    ctrl_state_t         r_state;
    logic [XLEN-1:0]     r_tgt;
    logic                r_src_irq;
    logic                r_lu_q;
    logic                r_irq_mask;

    logic                w_load_use;
    logic                w_irq_ev;
    logic                w_entry;
    logic                w_lu_stall;
    logic                w_redirect;
    logic                w_irq_take;
    logic [XLEN-1:0]     w_target;
    pipe_ctrl_t          w_ctrl;

    pipeline_ctrl_hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard (
        .i_id_valid   (id_valid),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_id_use_rs1 (id_use_rs1),
        .i_id_use_rs2 (id_use_rs2),
        .i_ex_load    (ex_load),
        .i_ex_rd      (ex_rd),
        .o_load_use   (w_load_use)
    );

    // An interrupt waits behind a taken branch so the redirected PC is what mepc captures;
    // once taken it stays masked until irq_pending drops while back in RUN.
    assign w_irq_ev = irq_pending && !br_taken && !r_irq_mask;
    assign w_entry  = (r_state == RUN) && (trap_req || w_irq_ev);

    always_comb begin
        w_ctrl     = '0;
        w_redirect = 1'b0;
        w_irq_take = 1'b0;
        w_lu_stall = 1'b0;
        w_target   = '0;
        case (r_state)
            RUN: begin
                w_target = br_target;
                if (w_entry) begin
                    w_ctrl.stall_if = 1'b1;
                    w_ctrl.stall_id = 1'b1;
                    w_ctrl.stall_ex = mem_busy;
                end else if (br_taken && !mem_busy) begin
                    w_redirect         = 1'b1;
                    w_ctrl.flush_front = 1'b1;
                end else if (mem_busy) begin
                    w_ctrl = stall_all();
                end else if (w_load_use && !r_lu_q) begin
                    w_ctrl.stall_if  = 1'b1;
                    w_ctrl.stall_id  = 1'b1;
                    w_ctrl.bubble_ex = 1'b1;
                    w_lu_stall       = 1'b1;
                end else if (if_busy) begin
                    w_ctrl.stall_if  = 1'b1;
                    w_ctrl.bubble_ex = 1'b1;
                end
            end
            DRAIN: begin
                w_ctrl = stall_all();
            end
            REDIRECT: begin
                w_redirect       = 1'b1;
                w_target         = r_tgt;
                w_ctrl.flush_all = 1'b1;
                w_irq_take       = r_src_irq;
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_tgt      <= '0;
            r_src_irq  <= 1'b0;
            r_lu_q     <= 1'b0;
            r_irq_mask <= 1'b0;
        end else begin
            r_lu_q <= w_lu_stall;
            case (r_state)
                RUN: begin
                    if (w_entry) begin
                        r_tgt     <= trap_req ? trap_target : irq_target;
                        r_src_irq <= !trap_req;
                        r_state   <= mem_busy ? DRAIN : REDIRECT;
                        if (!trap_req) begin
                            r_irq_mask <= 1'b1;
                        end
                    end else if (!irq_pending) begin
                        r_irq_mask <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        r_state <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Reset forces every control output low at once, even while inputs still request stalls.
    assign stall_if    = reset && w_ctrl.stall_if;
    assign stall_id    = reset && w_ctrl.stall_id;
    assign stall_ex    = reset && w_ctrl.stall_ex;
    assign bubble_ex   = reset && w_ctrl.bubble_ex;
    assign flush_front = reset && w_ctrl.flush_front;
    assign flush_all   = reset && w_ctrl.flush_all;
    assign pc_redirect = reset && w_redirect;
    assign irq_take    = reset && w_irq_take;
    assign pc_target   = reset ? w_target : '0;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: each step pushes its expected output vector,
// which is popped and compared on the falling edge of the same cycle.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        if_busy;
    logic        mem_busy;
    logic        br_taken;
    logic [63:0] br_target;
    logic        trap_req;
    logic [63:0] trap_target;
    logic        irq_pending;
    logic [63:0] irq_target;
    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        bubble_ex;
    logic        flush_front;
    logic        flush_all;
    logic        pc_redirect;
    logic [63:0] pc_target;
    logic        irq_take;
    ctrl_state_t dbg_state;

    logic [71:0] exp_q[$];
    string       tag_q[$];
    int          n_tests;
    int          n_fail;
    int          irq_cnt;

    pipeline_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_load     (ex_load),
        .ex_rd       (ex_rd),
        .if_busy     (if_busy),
        .mem_busy    (mem_busy),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap_req    (trap_req),
        .trap_target (trap_target),
        .irq_pending (irq_pending),
        .irq_target  (irq_target),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .bubble_ex   (bubble_ex),
        .flush_front (flush_front),
        .flush_all   (flush_all),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .irq_take    (irq_take),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_valid    = 1'b0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        ex_load     = 1'b0;
        ex_rd       = '0;
        if_busy     = 1'b0;
        mem_busy    = 1'b0;
        br_taken    = 1'b0;
        br_target   = '0;
        trap_req    = 1'b0;
        trap_target = '0;
        irq_pending = 1'b0;
        irq_target  = '0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        id_valid   = 1'b1;
        id_rs1     = r;
        id_use_rs1 = 1'b1;
        ex_load    = 1'b1;
        ex_rd      = r;
    endtask

    // flags order: stall_if stall_id stall_ex bubble_ex flush_front flush_all pc_redirect irq_take
    task automatic expect_out(input string tag, input logic [7:0] flags, input logic [63:0] tgt);
        exp_q.push_back({flags, tgt});
        tag_q.push_back(tag);
    endtask

    task automatic check();
        logic [71:0] e;
        logic [71:0] o;
        string       t;
        @(negedge clk);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = {stall_if, stall_id, stall_ex, bubble_ex, flush_front, flush_all,
                 pc_redirect, irq_take, pc_target};
            if (irq_take === 1'b1) irq_cnt++;
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, o, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        irq_cnt = 0;
        clear_inputs();
        reset    = 1'b0;
        mem_busy = 1'b1;
        trap_req = 1'b1;
        @(posedge clk);
        #1;
        expect_out("reset_hold", 8'b0000_0000, 64'h0); check();
        reset = 1'b1;
        clear_inputs();
        expect_out("run_idle", 8'b0000_0000, 64'h0); check();

        // load-use detection and single-cycle response
        set_load_use(5'd5);
        expect_out("lu_stall", 8'b1101_0000, 64'h0); check();
        expect_out("lu_once", 8'b0000_0000, 64'h0); check();
        set_load_use(5'd0);
        expect_out("lu_rd0", 8'b0000_0000, 64'h0); check();
        clear_inputs();
        id_valid = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1; ex_load = 1'b1; ex_rd = 5'd7;
        expect_out("lu_rs2", 8'b1101_0000, 64'h0); check();
        clear_inputs();
        expect_out("idle_a", 8'b0000_0000, 64'h0); check();
        set_load_use(5'd9); id_valid = 1'b0;
        expect_out("lu_novalid", 8'b0000_0000, 64'h0); check();
        set_load_use(5'd9); ex_load = 1'b0;
        expect_out("lu_noload", 8'b0000_0000, 64'h0); check();

        // branch redirect suppresses the load-use stall
        set_load_use(5'd5); br_taken = 1'b1; br_target = 64'h8000_0100;
        expect_out("br_lu", 8'b0000_1010, 64'h8000_0100); check();
        br_taken = 1'b0; br_target = '0;
        expect_out("lu_after_br", 8'b1101_0000, 64'h0); check();

        // memory and fetch stalls
        clear_inputs(); mem_busy = 1'b1;
        expect_out("mem_busy", 8'b1110_0000, 64'h0); check();
        br_taken = 1'b1; br_target = 64'h8000_0100;
        expect_out("br_membusy", 8'b1110_0000, 64'h8000_0100); check();
        clear_inputs(); mem_busy = 1'b1; set_load_use(5'd5);
        expect_out("mem_over_lu", 8'b1110_0000, 64'h0); check();
        clear_inputs(); if_busy = 1'b1;
        expect_out("if_busy", 8'b1001_0000, 64'h0); check();
        set_load_use(5'd6);
        expect_out("lu_over_if", 8'b1101_0000, 64'h0); check();

        // trap with memory busy for 3 cycles: drain, then redirect
        clear_inputs(); trap_req = 1'b1; trap_target = 64'h8000_0040; mem_busy = 1'b1;
        expect_out("trap_busy", 8'b1110_0000, 64'h0); check();
        trap_req = 1'b0; trap_target = '0; irq_pending = 1'b1; irq_target = 64'h8000_0200;
        expect_out("drain1", 8'b1110_0000, 64'h0); check();
        trap_req = 1'b1; trap_target = 64'h0000_dead;
        expect_out("drain2", 8'b1110_0000, 64'h0); check();
        clear_inputs();
        expect_out("drain3", 8'b1110_0000, 64'h0); check();
        expect_out("trap_redir", 8'b0000_0110, 64'h8000_0040); check();
        expect_out("trap_after", 8'b0000_0000, 64'h0); check();

        // interrupt held for 5 cycles yields a single irq_take
        irq_cnt = 0;
        irq_pending = 1'b1; irq_target = 64'h8000_0200;
        expect_out("irq_entry", 8'b1100_0000, 64'h0); check();
        expect_out("irq_redir", 8'b0000_0111, 64'h8000_0200); check();
        expect_out("irq_masked1", 8'b0000_0000, 64'h0); check();
        expect_out("irq_masked2", 8'b0000_0000, 64'h0); check();
        expect_out("irq_masked3", 8'b0000_0000, 64'h0); check();
        clear_inputs();
        expect_out("irq_off", 8'b0000_0000, 64'h0); check();
        n_tests++;
        assert (irq_cnt === 1) else begin
            n_fail++;
            $error("FAIL irq_once observed=%0d expected=1", irq_cnt);
        end

        // trap beats a same-cycle branch
        trap_req = 1'b1; trap_target = 64'h8000_0080; br_taken = 1'b1; br_target = 64'h8000_0300;
        expect_out("trap_br", 8'b1100_0000, 64'h8000_0300); check();
        clear_inputs();
        expect_out("trap_br_redir", 8'b0000_0110, 64'h8000_0080); check();

        // interrupt waits for a same-cycle branch, then enters
        irq_pending = 1'b1; irq_target = 64'h8000_0400; br_taken = 1'b1; br_target = 64'h8000_0500;
        expect_out("irq_br", 8'b0000_1010, 64'h8000_0500); check();
        br_taken = 1'b0; br_target = '0;
        expect_out("irq_br_entry", 8'b1100_0000, 64'h0); check();
        expect_out("irq_br_redir", 8'b0000_0111, 64'h8000_0400); check();
        clear_inputs();
        expect_out("idle_b", 8'b0000_0000, 64'h0); check();

        // reset in the middle of DRAIN
        trap_req = 1'b1; trap_target = 64'h8000_0040; mem_busy = 1'b1;
        expect_out("rst_trap", 8'b1110_0000, 64'h0); check();
        trap_req = 1'b0; trap_target = '0;
        expect_out("rst_drain", 8'b1110_0000, 64'h0); check();
        reset = 1'b0;
        #1;
        n_tests++;
        assert (dbg_state === RUN) else begin
            n_fail++;
            $error("FAIL rst_state observed=%0d expected=%0d", dbg_state, RUN);
        end
        expect_out("rst_async", 8'b0000_0000, 64'h0); check();
        reset = 1'b1; mem_busy = 1'b0;
        expect_out("rst_release", 8'b0000_0000, 64'h0); check();
        expect_out("rst_no_redir", 8'b0000_0000, 64'h0); check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
